// File: rtl/rec_buf_rotn.sv
// Rotating bank buffer: NUM_BUF banks, one stage-0 writer and NUM_RD+1 read ports.
// Optional written-bitmap clearing is enabled by defining REC_BUF_ROT_CLR_EN.
module rec_buf_rotn #(
    parameter int NUM_BUF = 3,
    parameter int NUM_RD  = 2,
    parameter int ADR_WD  = 5,
    parameter int DAT_WD  = 512,
    localparam int PTR_WD = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1,
    localparam int NP     = NUM_RD + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rotate_i,
    input  logic                 wr_ena_i,
    input  logic [ADR_WD-1:0]    wr_adr_i,
    input  logic [DAT_WD-1:0]    wr_dat_i,
    input  logic [NP-1:0]        rd_ena_i,
    input  logic [NP*ADR_WD-1:0] rd_adr_i,
    output logic [NP*DAT_WD-1:0] rd_dat_o,
    output logic [NP-1:0]        rd_val_o,
    output logic [PTR_WD-1:0]    buf_ptr_o
);

    localparam int DEPTH = 1 << ADR_WD;

    generate
        if (NUM_BUF < 2 || NUM_BUF > 8 || NUM_RD < 1 || NUM_RD > NUM_BUF - 1) begin : g_bad_param
            $error("rec_buf_rotn: illegal NUM_BUF/NUM_RD combination");
        end
    endgenerate

    logic [PTR_WD-1:0] r_base;
    logic [PTR_WD-1:0] w_base_next;
    logic [PTR_WD-1:0] w_bank [NP];
    logic [DAT_WD-1:0] r_mem [NUM_BUF][DEPTH];
    logic [DAT_WD-1:0] r_rd_dat [NP];
    logic [NP-1:0]     r_rd_val;

    assign w_base_next = (r_base == PTR_WD'(NUM_BUF - 1)) ? '0 : r_base + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base <= '0;
        end else if (rotate_i) begin
            r_base <= w_base_next;
        end
    end

    // Bank contents carry no reset so the arrays can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ena_i) begin
            r_mem[w_bank[0]][wr_adr_i] <= wr_dat_i;
        end
    end

`ifdef REC_BUF_ROT_CLR_EN
    logic [DEPTH-1:0] r_map [NUM_BUF];

    // The bank entering stage 0 is cleared while a same-edge write still marks the old bank.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < NUM_BUF; b++) begin
                r_map[b] <= '0;
            end
        end else begin
            if (rotate_i) begin
                r_map[w_base_next] <= '0;
            end
            if (wr_ena_i) begin
                r_map[w_bank[0]][wr_adr_i] <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_val <= '0;
        end else begin
            r_rd_val <= rd_ena_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            logic [PTR_WD:0]    w_sum;
            logic [ADR_WD-1:0]  w_adr;
            logic [DAT_WD-1:0]  w_rdata;

            // Stage gi looks gi banks behind the base pointer, modulo NUM_BUF.
            assign w_sum = {1'b0, r_base} + (PTR_WD + 1)'(NUM_BUF - gi);
            assign w_bank[gi] = (w_sum >= (PTR_WD + 1)'(NUM_BUF))
                              ? PTR_WD'(w_sum - (PTR_WD + 1)'(NUM_BUF))
                              : w_sum[PTR_WD-1:0];
            assign w_adr = rd_adr_i[gi*ADR_WD +: ADR_WD];

`ifdef REC_BUF_ROT_CLR_EN
            assign w_rdata = r_map[w_bank[gi]][w_adr] ? r_mem[w_bank[gi]][w_adr] : '0;
`else
            assign w_rdata = r_mem[w_bank[gi]][w_adr];
`endif

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_rd_dat[gi] <= '0;
                end else if (rd_ena_i[gi]) begin
                    r_rd_dat[gi] <= w_rdata;
                end
            end

            assign rd_dat_o[gi*DAT_WD +: DAT_WD] = r_rd_dat[gi];
        end
    endgenerate

    assign rd_val_o  = r_rd_val;
    assign buf_ptr_o = r_base;

endmodule
